// File: rtl/divide_pkg.sv
// Shared width and FSM state encoding for the sequential unsigned divider.
package divide_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;
endpackage

// File: rtl/divide_u32_if.sv
// Request/result bundle for divide_u32: operands and start in, quotient/remainder/status out.
interface divide_u32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] R;
  logic             ok;
  logic             err;

  modport master (output start, A, B, input D, R, ok, err);
  modport slave  (input start, A, B, output D, R, ok, err);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], q_msb};
    diff    = shifted - {1'b0, divisor};
    // A set rem_in MSB means the true shifted value exceeds any divisor;
    // the low WIDTH+1 bits of the difference are still exact in that case.
    q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted;
  end
endmodule

// File: rtl/divide_u32.sv
// Sequential unsigned divider: one quotient bit per clock, divide-by-zero
// flagged through err with D all ones and R = A.
module divide_u32
  import divide_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  divide_u32_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .q_msb   (q[WIDTH-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q       <= '0;
      rem     <= '0;
      divisor <= '0;
      count   <= '0;
      bus.D   <= '0;
      bus.R   <= '0;
      bus.ok  <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            divisor <= bus.B;
            q       <= bus.A;
            rem     <= '0;
            count   <= CW'(WIDTH);
            if (bus.B == '0) begin
              state   <= DONE;
              bus.D   <= '1;
              bus.R   <= bus.A;
              bus.ok  <= 1'b1;
              bus.err <= 1'b1;
            end else begin
              state   <= RUN;
              bus.ok  <= 1'b0;
              bus.err <= 1'b0;
            end
          end
        end
        RUN: begin
          // WIDTH iteration edges, then one edge to publish the result.
          if (count != '0) begin
            rem   <= rem_next;
            q     <= {q[WIDTH-2:0], q_bit};
            count <= count - CW'(1);
          end else begin
            state   <= DONE;
            bus.D   <= q;
            bus.R   <= rem[WIDTH-1:0];
            bus.ok  <= 1'b1;
            bus.err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divide_u32.sv
// Directed-vector bench for divide_u32 with hand-computed quotients and remainders.
`timescale 1ns/100ps
module tb_divide_u32;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  divide_u32_if #(.WIDTH(32)) bus ();

  divide_u32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation; poke>0 re-pulses start with other operands that many
  // cycles into the run. Pads to 36 cycles so runs are 72 ns apart.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic [31:0] er, input logic eerr,
                        input int elat, input int poke);
    int cyc;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.ok && cyc < 40) begin
      if (cyc == poke) begin
        bus.A = 32'd5;
        bus.B = 32'd1;
        bus.start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    check({tag, ".lat"}, 32'(cyc), 32'(elat));
    check({tag, ".ok"},  {31'd0, bus.ok},  32'd1);
    check({tag, ".err"}, {31'd0, bus.err}, {31'd0, eerr});
    check({tag, ".D"},   bus.D, ed);
    check({tag, ".R"},   bus.R, er);
    repeat (35 - cyc) @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("rst.D",   bus.D, 32'd0);
    check("rst.R",   bus.R, 32'd0);
    check("rst.ok",  {31'd0, bus.ok},  32'd0);
    check("rst.err", {31'd0, bus.err}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    do_div("7/3",    32'd7,   32'd3, 32'd2,  32'd1, 1'b0, 33, -1);
    do_div("13/5",   32'd13,  32'd5, 32'd2,  32'd3, 1'b0, 33, -1);
    do_div("60/7",   32'd60,  32'd7, 32'd8,  32'd4, 1'b0, 33, -1);
    do_div("82/6",   32'd82,  32'd6, 32'd13, 32'd4, 1'b0, 33, -1);
    do_div("56/7",   32'd56,  32'd7, 32'd8,  32'd0, 1'b0, 33, -1);
    do_div("100/7",  32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);
    do_div("110/7",  32'd110, 32'd7, 32'd15, 32'd5, 1'b0, 33, -1);
    do_div("div0",   32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0, -1);
    do_div("3/7",    32'd3,   32'd7, 32'd0,  32'd3, 1'b0, 33, -1);
    do_div("max/1",  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, -1);
    do_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33, -1);
    do_div("poke",   32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10);

    // Abort a run with reset at cycle 15, then confirm a clean rerun.
    @(negedge clk);
    bus.A = 32'd110;
    bus.B = 32'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("hold.D",  bus.D, 32'd14);
    check("hold.R",  bus.R, 32'd2);
    check("hold.ok", {31'd0, bus.ok}, 32'd0);
    repeat (10) @(negedge clk);
    #0.5 reset = 1'b0;
    #0.2;
    check("abort.D",  bus.D, 32'd0);
    check("abort.R",  bus.R, 32'd0);
    check("abort.ok", {31'd0, bus.ok}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort.hold", {31'd0, bus.ok}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_div("after", 32'd110, 32'd7, 32'd15, 32'd5, 1'b0, 33, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
